// File: rtl/c_demux_split32_pkg.sv
// c_demux_split32_pkg: shared widths and state encoding for the split dispatcher
package c_demux_split32_pkg;
  localparam int SEL_W   = 5;
  localparam int MAX_OUT = 32;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/c_demux_split32_onehot_dec.sv
// c_onehot_dec: gated index-to-one-hot decoder for the output channel valids
module c_onehot_dec
  import c_demux_split32_pkg::*;
#(
  parameter int NUM_OUT = 32
) (
  input  logic               en,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot
);
  // one bit per channel, all clear when not enabled
  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_OUT; k++)
      onehot[k] = en && (sel == SEL_W'(k));
  end
endmodule

// File: rtl/c_demux_split32.sv
// c_demux_split32: one-entry registered fan-out of a shared request to NUM_OUT channels
module c_demux_split32
  import c_demux_split32_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT    = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_free,
  output logic [NUM_OUT-1:0]    o_drive,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic [NUM_OUT-1:0]    i_freeNext,
  output logic                  o_dropErr,
  output logic [CNT_W-1:0]      o_sentCount
);
  state_e                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  full, fire_out, accept, in_range, valid;

  assign full = (state_q == FULL);

  c_onehot_dec #(.NUM_OUT(NUM_OUT)) u_dec (
    .en     (full),
    .sel    (sel_q),
    .onehot (o_drive)
  );

  // handshake: the entry drains when its own channel is ready, and refills in the same cycle
  always_comb begin
    fire_out = |(o_drive & i_freeNext);
    o_free   = ~full | fire_out;
    accept   = i_drive & o_free;
    in_range = 32'(i_sel) < 32'(NUM_OUT);
    valid    = accept & in_range;
  end

  // next state: load on valid accept, empty on drain, out-of-range requests only raise the error
  always_comb begin
    state_d = valid ? FULL : (fire_out ? EMPTY : state_q);
    sel_d   = valid ? i_sel : sel_q;
    data_d  = valid ? i_data : data_q;
    err_d   = accept & ~in_range;
    cnt_d   = cnt_q + CNT_W'(fire_out);
  end

  // state registers; reset discards any pending entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_data      = data_q;
  assign o_dropErr   = err_q;
  assign o_sentCount = cnt_q;
endmodule

// File: tb/tb_c_demux_split32.sv
// tb_c_demux_split32: directed self-checking bench for the split dispatcher
module tb_c_demux_split32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_drive = 1'b0;
  logic [4:0]  i_sel = '0;
  logic [31:0] i_data = '0;
  logic [31:0] i_freeNext = '0;
  logic        o_free, o_dropErr, o_free20, o_dropErr20, o_free4, o_dropErr4;
  logic [31:0] o_drive, o_data, o_data20, o_drive4, o_data4;
  logic [19:0] o_drive20;
  logic [15:0] o_sentCount, o_sentCount20;
  logic [3:0]  o_sentCount4;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  c_demux_split32 dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_sel(i_sel), .i_data(i_data),
    .o_free(o_free), .o_drive(o_drive), .o_data(o_data), .i_freeNext(i_freeNext),
    .o_dropErr(o_dropErr), .o_sentCount(o_sentCount)
  );

  c_demux_split32 #(.NUM_OUT(20)) dut20 (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_sel(i_sel), .i_data(i_data),
    .o_free(o_free20), .o_drive(o_drive20), .o_data(o_data20), .i_freeNext(i_freeNext[19:0]),
    .o_dropErr(o_dropErr20), .o_sentCount(o_sentCount20)
  );

  c_demux_split32 #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_sel(i_sel), .i_data(i_data),
    .o_free(o_free4), .o_drive(o_drive4), .o_data(o_data4), .i_freeNext(i_freeNext),
    .o_dropErr(o_dropErr4), .o_sentCount(o_sentCount4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; i_drive = 1'b0; i_sel = '0; i_data = '0; i_freeNext = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // 1 reset
    do_reset();
    chk("rst_drive", 64'(o_drive), 64'h0);
    chk("rst_free", 64'(o_free), 64'h1);
    chk("rst_data", 64'(o_data), 64'h0);
    chk("rst_cnt", 64'(o_sentCount), 64'h0);
    chk("rst_err", 64'(o_dropErr), 64'h0);
    // 2 single transfer with backpressure
    i_drive = 1'b1; i_sel = 5'd7; i_data = 32'hDEADBEEF; i_freeNext = '0;
    step();
    i_drive = 1'b0; i_sel = '0; i_data = '0;
    chk("single_drive", 64'(o_drive), 64'h80);
    chk("single_data", 64'(o_data), 64'hDEADBEEF);
    chk("single_free", 64'(o_free), 64'h0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_drive", 64'(o_drive), 64'h80);
      chk("hold_data", 64'(o_data), 64'hDEADBEEF);
    end
    i_freeNext = 32'h80;
    #1;
    chk("single_free_fire", 64'(o_free), 64'h1);
    step();
    i_freeNext = '0;
    chk("single_empty", 64'(o_drive), 64'h0);
    chk("single_cnt", 64'(o_sentCount), 64'h1);
    // 3 streaming over all channels
    do_reset();
    i_freeNext = 32'hFFFFFFFF;
    for (int k = 0; k < 32; k++) begin
      i_drive = 1'b1; i_sel = 5'(k); i_data = 32'(k) + 32'd100;
      #1;
      chk("stream_free", 64'(o_free), 64'h1);
      step();
      chk("stream_drive", 64'(o_drive), 64'(32'h1 << k));
      chk("stream_data", 64'(o_data), 64'(k + 100));
    end
    i_drive = 1'b0;
    step();
    chk("stream_idle", 64'(o_drive), 64'h0);
    chk("stream_cnt", 64'(o_sentCount), 64'd32);
    chk("stream_cnt4_wrap", 64'(o_sentCount4), 64'h0);
    // 4 ready on the wrong channels only
    do_reset();
    i_drive = 1'b1; i_sel = 5'd3; i_data = 32'h0000_0033; i_freeNext = 32'hFFFFFFF7;
    step();
    i_sel = 5'd5; i_data = 32'h0000_0055;
    chk("wrong_drive", 64'(o_drive), 64'h8);
    chk("wrong_free", 64'(o_free), 64'h0);
    step();
    step();
    chk("wrong_hold", 64'(o_drive), 64'h8);
    chk("wrong_data", 64'(o_data), 64'h33);
    chk("wrong_cnt", 64'(o_sentCount), 64'h0);
    // 5 out-of-range index on a 20-channel instance
    do_reset();
    i_drive = 1'b1; i_sel = 5'd25; i_data = 32'h1234; i_freeNext = '0;
    #1;
    chk("inv_free", 64'(o_free20), 64'h1);
    step();
    i_drive = 1'b0;
    chk("inv_err", 64'(o_dropErr20), 64'h1);
    chk("inv_drive", 64'(o_drive20), 64'h0);
    chk("inv_cnt", 64'(o_sentCount20), 64'h0);
    step();
    chk("inv_err_clear", 64'(o_dropErr20), 64'h0);
    i_drive = 1'b1; i_sel = 5'd20;
    step();
    chk("inv_b2b_1", 64'(o_dropErr20), 64'h1);
    i_sel = 5'd31;
    step();
    chk("inv_b2b_2", 64'(o_dropErr20), 64'h1);
    i_drive = 1'b0;
    step();
    chk("inv_b2b_end", 64'(o_dropErr20), 64'h0);
    chk("inv_b2b_drive", 64'(o_drive20), 64'h0);
    i_drive = 1'b1; i_sel = 5'd19; i_data = 32'h19;
    step();
    i_drive = 1'b0;
    chk("edge_valid_drive", 64'(o_drive20), 64'(20'h80000));
    chk("edge_valid_err", 64'(o_dropErr20), 64'h0);
    // 6 reset mid-flight, then counter wrap
    do_reset();
    i_drive = 1'b1; i_sel = 5'd12; i_data = 32'hCAFE;
    step();
    i_drive = 1'b0;
    chk("mid_drive", 64'(o_drive), 64'h1000);
    i_freeNext = 32'h1000; rst = 1'b1;
    step();
    rst = 1'b0; i_freeNext = '0;
    #1;
    chk("mid_rst_drive", 64'(o_drive), 64'h0);
    chk("mid_rst_cnt", 64'(o_sentCount), 64'h0);
    chk("mid_rst_free", 64'(o_free), 64'h1);
    i_freeNext = 32'hFFFFFFFF;
    for (int k = 0; k < 16; k++) begin
      i_drive = 1'b1; i_sel = 5'd0; i_data = 32'(k);
      step();
    end
    chk("wrap_cnt4_15", 64'(o_sentCount4), 64'd15);
    i_drive = 1'b0;
    step();
    chk("wrap_cnt4_0", 64'(o_sentCount4), 64'h0);
    chk("wrap_cnt16", 64'(o_sentCount), 64'd16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
